// File: rtl/schedule_sequencer.sv
// Weekly thermostat schedule sequencer.
// Watches day/hour/minute from the time keeper. Whenever the time changes it scans the
// schedule table, one entry per clock. The highest-index matching entry then loads the
// active setpoint. A manual override holds its setpoint until the next matching entry.
// Ports:
//   i_clk, i_reset                        clock, synchronous active-high reset
//   i_day/i_hour/i_minute                 current time (one-hot day, 0..23, 0..59)
//   i_wr_*                                table write port (one entry per cycle)
//   i_override_en/i_override_setpoint     manual setpoint pulse
//   o_setpoint, o_active_idx              active setpoint and the entry that set it
//   o_override_active, o_busy, o_event    override flag, scan in progress, apply pulse
module schedule_sequencer #(
  parameter int unsigned g_num_entries      = 8,
  parameter int unsigned g_addr_w           = 3,
  parameter logic [6:0]  g_default_setpoint = 7'd68
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [6:0]          i_day,
  input  logic [4:0]          i_hour,
  input  logic [5:0]          i_minute,
  input  logic                i_wr_en,
  input  logic [g_addr_w-1:0] i_wr_addr,
  input  logic                i_wr_valid,
  input  logic [6:0]          i_wr_day_mask,
  input  logic [4:0]          i_wr_hour,
  input  logic [5:0]          i_wr_minute,
  input  logic [6:0]          i_wr_setpoint,
  input  logic                i_override_en,
  input  logic [6:0]          i_override_setpoint,
  output logic [6:0]          o_setpoint,
  output logic [g_addr_w-1:0] o_active_idx,
  output logic                o_override_active,
  output logic                o_busy,
  output logic                o_event
);

  localparam int unsigned TIME_W = 18;
  localparam logic [g_addr_w-1:0] LAST_IDX = g_addr_w'(g_num_entries - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY} state_t;

  state_t              state;
  logic [TIME_W-1:0]   prev_time;
  logic [TIME_W-1:0]   snap_time;
  logic [TIME_W-1:0]   now_time;
  logic                changed;
  logic                pending;
  logic [g_addr_w-1:0] idx;
  logic                found;
  logic [g_addr_w-1:0] found_idx;
  logic [6:0]          found_sp;
  logic                hit;
  logic                wr_ok;

  // Schedule table
  logic       t_valid    [g_num_entries];
  logic [6:0] t_mask     [g_num_entries];
  logic [4:0] t_hour     [g_num_entries];
  logic [5:0] t_minute   [g_num_entries];
  logic [6:0] t_setpoint [g_num_entries];

  assign now_time = {i_day, i_hour, i_minute};
  assign changed  = (now_time != prev_time);
  assign o_busy   = (state != S_IDLE);

  // Addresses past the table end are dropped; with a full power-of-two table none exist.
  if (g_num_entries == (32'd1 << g_addr_w)) begin : g_full
    assign wr_ok = 1'b1;
  end else begin : g_partial
    assign wr_ok = (32'(i_wr_addr) < g_num_entries);
  end

  // Match of the entry under scan against the snapshot; out-of-range entry times never match.
  assign hit = t_valid[idx]
            && ((t_mask[idx] & snap_time[17:11]) != 7'd0)
            && (t_hour[idx] == snap_time[10:6])
            && (t_minute[idx] == snap_time[5:0])
            && (t_hour[idx] <= 5'd23)
            && (t_minute[idx] <= 6'd59);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= S_IDLE;
      prev_time         <= now_time;
      snap_time         <= '0;
      pending           <= 1'b0;
      idx               <= '0;
      found             <= 1'b0;
      found_idx         <= '0;
      found_sp          <= '0;
      o_setpoint        <= g_default_setpoint;
      o_active_idx      <= '0;
      o_override_active <= 1'b0;
      o_event           <= 1'b0;
      for (int unsigned i = 0; i < g_num_entries; i++) begin
        t_valid[i] <= 1'b0;
      end
    end else begin
      prev_time <= now_time;
      o_event   <= 1'b0;

      if (i_wr_en && wr_ok) begin
        t_valid[i_wr_addr]    <= i_wr_valid;
        t_mask[i_wr_addr]     <= i_wr_day_mask;
        t_hour[i_wr_addr]     <= i_wr_hour;
        t_minute[i_wr_addr]   <= i_wr_minute;
        t_setpoint[i_wr_addr] <= i_wr_setpoint;
      end

      case (state)
        S_IDLE: begin
          if (changed) begin
            snap_time <= now_time;
            idx       <= '0;
            found     <= 1'b0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (changed) pending <= 1'b1;
          // Ascending scan: later hits overwrite, so the highest index wins.
          if (hit) begin
            found     <= 1'b1;
            found_idx <= idx;
            found_sp  <= t_setpoint[idx];
          end
          if (idx == LAST_IDX) begin
            state <= S_APPLY;
          end else begin
            idx <= idx + g_addr_w'(1);
          end
        end
        S_APPLY: begin
          if (found && !i_override_en) begin
            o_setpoint        <= found_sp;
            o_active_idx      <= found_idx;
            o_override_active <= 1'b0;
            o_event           <= 1'b1;
          end
          // Any change seen during the scan (or now) restarts on the latest time.
          if (pending || changed) begin
            snap_time <= now_time;
            idx       <= '0;
            found     <= 1'b0;
            pending   <= 1'b0;
            state     <= S_SCAN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Override is last so it wins over a same-cycle apply.
      if (i_override_en) begin
        o_setpoint        <= i_override_setpoint;
        o_override_active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_schedule_sequencer.sv
// Directed self-checking bench for schedule_sequencer (8 entries).
module tb_schedule_sequencer;

  localparam int unsigned N = 8;
  localparam logic [6:0] SUN = 7'b0000001;
  localparam logic [6:0] MON = 7'b0000010;
  localparam logic [6:0] TUE = 7'b0000100;
  localparam logic [6:0] WED = 7'b0001000;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] day;
  logic [4:0] hour;
  logic [5:0] minute;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       wr_valid;
  logic [6:0] wr_day_mask;
  logic [4:0] wr_hour;
  logic [5:0] wr_minute;
  logic [6:0] wr_setpoint;
  logic       override_en;
  logic [6:0] override_setpoint;
  logic [6:0] setpoint;
  logic [2:0] active_idx;
  logic       override_active;
  logic       busy;
  logic       evt;

  int n_tests = 0;
  int n_fail  = 0;

  schedule_sequencer #(
    .g_num_entries(8), .g_addr_w(3), .g_default_setpoint(7'd68)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_day(day), .i_hour(hour), .i_minute(minute),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_valid(wr_valid),
    .i_wr_day_mask(wr_day_mask), .i_wr_hour(wr_hour), .i_wr_minute(wr_minute),
    .i_wr_setpoint(wr_setpoint),
    .i_override_en(override_en), .i_override_setpoint(override_setpoint),
    .o_setpoint(setpoint), .o_active_idx(active_idx),
    .o_override_active(override_active), .o_busy(busy), .o_event(evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [6:0] d, input int h, input int m);
    day    = d;
    hour   = 5'(h);
    minute = 6'(m);
  endtask

  task automatic write_entry(input int addr, input logic v, input logic [6:0] mask,
                             input int h, input int m, input int sp);
    wr_en       = 1'b1;
    wr_addr     = 3'(addr);
    wr_valid    = v;
    wr_day_mask = mask;
    wr_hour     = 5'(h);
    wr_minute   = 6'(m);
    wr_setpoint = 7'(sp);
    tick();
    wr_en = 1'b0;
  endtask

  // Run n cycles, counting event pulses and busy cycles.
  task automatic run(input int n, output int ev_cnt, output int busy_cnt);
    ev_cnt   = 0;
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (evt)  ev_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    int ev;
    int bc;
    int ev_at [1:11];
    int busy_at1;

    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_valid = 1'b0; wr_day_mask = '0;
    wr_hour = '0; wr_minute = '0; wr_setpoint = '0;
    override_en = 1'b0; override_setpoint = '0;
    set_time(SUN, 0, 0);
    tick(); tick();
    reset = 1'b0;

    // 1: reset values, empty table never fires
    check("rst_setpoint", int'(setpoint), 68);
    check("rst_idx", int'(active_idx), 0);
    check("rst_override", int'(override_active), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_event", int'(evt), 0);
    set_time(SUN, 0, 1);
    run(12, ev, bc);
    set_time(SUN, 0, 2);
    run(12, ev, bc);
    check("empty_no_event", ev, 0);
    check("empty_setpoint", int'(setpoint), 68);

    // 2: single entry, latency of the event pulse
    write_entry(0, 1'b1, MON, 6, 30, 72);
    set_time(MON, 6, 29);
    run(12, ev, bc);
    check("no_match_0629", ev, 0);
    set_time(MON, 6, 30);
    busy_at1 = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      ev_at[k] = int'(evt);
      if (k == 1) busy_at1 = int'(busy);
      if (k == 10) begin
        check("lat_setpoint", int'(setpoint), 72);
        check("lat_idx", int'(active_idx), 0);
        check("lat_busy_done", int'(busy), 0);
      end
    end
    check("lat_busy_start", busy_at1, 1);
    check("lat_event_k9", ev_at[9], 0);
    check("lat_event_k10", ev_at[10], 1);
    check("lat_event_k11", ev_at[11], 0);

    // 3: highest matching index wins; day mask, zero day, out-of-range entry
    write_entry(2, 1'b1, MON, 6, 30, 70);
    write_entry(5, 1'b1, MON, 6, 30, 75);
    write_entry(7, 1'b1, 7'h7F, 24, 0, 90);
    set_time(MON, 6, 31);
    run(12, ev, bc);
    set_time(MON, 6, 30);
    run(12, ev, bc);
    check("multi_event", ev, 1);
    check("multi_setpoint", int'(setpoint), 75);
    check("multi_idx", int'(active_idx), 5);
    set_time(TUE, 6, 30);
    run(12, ev, bc);
    check("wrong_day_event", ev, 0);
    check("wrong_day_setpoint", int'(setpoint), 75);
    set_time(7'd0, 6, 31);
    run(12, ev, bc);
    set_time(7'd0, 6, 30);
    run(12, ev, bc);
    check("zero_day_event", ev, 0);
    set_time(MON, 24, 0);
    run(12, ev, bc);
    check("bad_hour_event", ev, 0);
    check("bad_hour_setpoint", int'(setpoint), 75);

    // 4: override holds until the next matching entry
    override_en = 1'b1;
    override_setpoint = 7'd60;
    tick();
    override_en = 1'b0;
    check("ovr_setpoint", int'(setpoint), 60);
    check("ovr_active", int'(override_active), 1);
    write_entry(3, 1'b1, TUE, 7, 0, 72);
    set_time(TUE, 6, 59);
    run(12, ev, bc);
    check("ovr_hold_setpoint", int'(setpoint), 60);
    check("ovr_hold_active", int'(override_active), 1);
    set_time(TUE, 7, 0);
    run(12, ev, bc);
    check("ovr_end_event", ev, 1);
    check("ovr_end_setpoint", int'(setpoint), 72);
    check("ovr_end_idx", int'(active_idx), 3);
    check("ovr_end_active", int'(override_active), 0);

    // 5: two changes during a scan collapse into one rescan of the latest time
    write_entry(6, 1'b1, WED, 8, 0, 80);
    set_time(WED, 7, 58);
    ev = 0;
    bc = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (evt)  ev++;
      if (busy) bc++;
      if (k == 2) set_time(WED, 7, 59);
      if (k == 4) set_time(WED, 8, 0);
    end
    check("pend_events", ev, 1);
    check("pend_busy_cycles", bc, 2 * (int'(N) + 1));
    check("pend_setpoint", int'(setpoint), 80);
    check("pend_idx", int'(active_idx), 6);

    // 6: reset mid-scan restores reset values and clears the table
    set_time(WED, 7, 59);
    run(12, ev, bc);
    set_time(WED, 8, 0);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_setpoint", int'(setpoint), 68);
    check("mid_rst_idx", int'(active_idx), 0);
    check("mid_rst_override", int'(override_active), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_event", int'(evt), 0);
    run(12, ev, bc);
    check("mid_rst_no_resume", bc, 0);
    set_time(WED, 7, 59);
    run(12, ev, bc);
    set_time(WED, 8, 0);
    run(12, ev, bc);
    check("cleared_no_event", ev, 0);
    check("cleared_setpoint", int'(setpoint), 68);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
